// File: rtl/section_meter_pkg.sv
// Shared helpers for the section meters: accumulator init values and channel slicing.
// Widths up to MAX_WIDTH bits are supported; callers truncate results to their own WIDTH.
package section_meter_pkg;

    localparam int MAX_WIDTH = 64;

    // Initial running minimum: all ones when unsigned, most positive value when signed.
    function automatic logic [MAX_WIDTH-1:0] min_init(input int width, input bit is_signed);
        logic [MAX_WIDTH-1:0] all_ones;
        all_ones = '1;
        if (is_signed)
            return all_ones >> (MAX_WIDTH - width + 1);
        else
            return all_ones >> (MAX_WIDTH - width);
    endfunction

    // Initial running maximum: zero when unsigned, most negative value when signed.
    function automatic logic [MAX_WIDTH-1:0] max_init(input int width, input bit is_signed);
        logic [MAX_WIDTH-1:0] one;
        one = 1;
        if (is_signed)
            return one << (width - 1);
        else
            return '0;
    endfunction

    // LSB position of a channel inside a packed multi-channel bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/section_min_max_lane.sv
// One channel of the section meter: running min/max accumulators plus the result registers.
// Optional absolute-peak output is built only when SECTION_MIN_MAX_PEAK_EN is defined.
module section_min_max_lane
    import section_meter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_sample,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_max
`ifdef SECTION_MIN_MAX_PEAK_EN
    ,
    output logic [WIDTH-1:0] o_peak
`endif
);

    localparam logic [WIDTH-1:0] MIN_INIT = WIDTH'(min_init(WIDTH, SIGNED != 0));
    localparam logic [WIDTH-1:0] MAX_INIT = WIDTH'(max_init(WIDTH, SIGNED != 0));

    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_out_min;
    logic [WIDTH-1:0] r_out_max;
    logic             w_lt_min;
    logic             w_gt_max;
    logic [WIDTH-1:0] w_new_min;
    logic [WIDTH-1:0] w_new_max;

    // Strict comparisons so that equal samples leave the running values untouched.
    always_comb begin
        if (SIGNED != 0) begin
            w_lt_min = $signed(i_sample) < $signed(r_min);
            w_gt_max = $signed(i_sample) > $signed(r_max);
        end else begin
            w_lt_min = i_sample < r_min;
            w_gt_max = i_sample > r_max;
        end
        w_new_min = w_lt_min ? i_sample : r_min;
        w_new_max = w_gt_max ? i_sample : r_max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_min     <= MIN_INIT;
            r_max     <= MAX_INIT;
            r_out_min <= MIN_INIT;
            r_out_max <= MAX_INIT;
        end else if (i_accept) begin
            if (i_last) begin
                r_out_min <= w_new_min;
                r_out_max <= w_new_max;
                r_min     <= MIN_INIT;
                r_max     <= MAX_INIT;
            end else begin
                r_min     <= w_new_min;
                r_max     <= w_new_max;
            end
        end
    end

    assign o_min = r_out_min;
    assign o_max = r_out_max;

`ifdef SECTION_MIN_MAX_PEAK_EN
    logic [WIDTH-1:0] r_out_peak;
    logic [WIDTH-1:0] w_mag_min;
    logic [WIDTH-1:0] w_mag_max;
    logic [WIDTH-1:0] w_peak;

    // The most negative value has no positive twin, so its magnitude saturates.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v == MAX_INIT)
            return MIN_INIT;
        else if (v[WIDTH-1])
            return -v;
        else
            return v;
    endfunction

    always_comb begin
        w_mag_min = magnitude(w_new_min);
        w_mag_max = magnitude(w_new_max);
        if (SIGNED != 0)
            w_peak = (w_mag_min > w_mag_max) ? w_mag_min : w_mag_max;
        else
            w_peak = w_new_max;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_out_peak <= '0;
        else if (i_accept && i_last)
            r_out_peak <= w_peak;
    end

    assign o_peak = r_out_peak;
`endif

endmodule

// File: rtl/section_min_max_multi.sv
// Multi-channel section min/max meter with a double-buffered result (no dead cycle between sections).
// Define SECTION_MIN_MAX_PEAK_EN to add the per-channel absolute-peak output.
module section_min_max_multi
    import section_meter_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_COUNT = 16,
    parameter int SIGNED       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [CHANNELS*WIDTH-1:0] i_value,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [CHANNELS*WIDTH-1:0] o_min_value,
    output logic [CHANNELS*WIDTH-1:0] o_max_value
`ifdef SECTION_MIN_MAX_PEAK_EN
    ,
    output logic [CHANNELS*WIDTH-1:0] o_peak_value
`endif
);

    localparam int               CNT_W    = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_COUNT - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             w_last;
    logic             w_accept;
    logic             w_last_accept;

    // Only the closing beat must wait, and only if the previous result is still unread.
    assign w_last        = (r_count == LAST_IDX);
    assign i_ready       = !(w_last && r_valid && !o_ready);
    assign w_accept      = i_valid && i_ready;
    assign w_last_accept = w_accept && w_last;
    assign o_valid       = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept)
                r_count <= w_last ? '0 : r_count + 1'b1;
            if (w_last_accept)
                r_valid <= 1'b1;
            else if (o_ready)
                r_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        section_min_max_lane #(
            .WIDTH  (WIDTH),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_accept (w_accept),
            .i_last   (w_last),
            .i_sample (i_value[lane_lsb(k, WIDTH) +: WIDTH]),
            .o_min    (o_min_value[lane_lsb(k, WIDTH) +: WIDTH]),
            .o_max    (o_max_value[lane_lsb(k, WIDTH) +: WIDTH])
`ifdef SECTION_MIN_MAX_PEAK_EN
            ,
            .o_peak   (o_peak_value[lane_lsb(k, WIDTH) +: WIDTH])
`endif
        );
    end

endmodule

// File: tb/tb_section_min_max_multi.sv
// Self-checking bench: an unsigned and a signed meter share one stimulus stream and one transaction-level model.
// Honours SECTION_MIN_MAX_PEAK_EN when defined.
module tb_section_min_max_multi;

    localparam int W = 16;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iValid = 1'b0;
    logic [31:0] iValue = '0;
    logic        oReady = 1'b1;

    logic        uReady, uValid, sReady, sValid;
    logic [31:0] uMin, uMax, sMin, sMax;
`ifdef SECTION_MIN_MAX_PEAK_EN
    logic [31:0] uPeak, sPeak;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: samples of the section in progress and the results last published.
    int          cnt = 0;
    bit          expValid = 1'b0;
    bit          expReady = 1'b1;
    logic [15:0] secBuf [2][N];
    logic [31:0] expUMin, expUMax, expSMin, expSMax, expUPeak, expSPeak;

    always #5 clk = ~clk;

    section_min_max_multi #(.WIDTH(W), .CHANNELS(2), .SAMPLE_COUNT(N), .SIGNED(0)) dutU (
        .clk(clk), .reset(reset), .i_valid(iValid), .i_ready(uReady), .i_value(iValue),
        .o_valid(uValid), .o_ready(oReady), .o_min_value(uMin), .o_max_value(uMax)
`ifdef SECTION_MIN_MAX_PEAK_EN
        , .o_peak_value(uPeak)
`endif
    );

    section_min_max_multi #(.WIDTH(W), .CHANNELS(2), .SAMPLE_COUNT(N), .SIGNED(1)) dutS (
        .clk(clk), .reset(reset), .i_valid(iValid), .i_ready(sReady), .i_value(iValue),
        .o_valid(sValid), .o_ready(oReady), .o_min_value(sMin), .o_max_value(sMax)
`ifdef SECTION_MIN_MAX_PEAK_EN
        , .o_peak_value(sPeak)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Section results from the stored samples with plain integer arithmetic.
    task automatic computeSection();
        for (int ch = 0; ch < 2; ch++) begin
            int umin = 65535, umax = 0, smin = 32767, smax = -32768, a, b, p;
            for (int i = 0; i < N; i++) begin
                int u = int'(secBuf[ch][i]);
                int s = int'($signed(secBuf[ch][i]));
                if (u < umin) umin = u;
                if (u > umax) umax = u;
                if (s < smin) smin = s;
                if (s > smax) smax = s;
            end
            a = (smin < 0) ? -smin : smin;
            b = (smax < 0) ? -smax : smax;
            p = (a > b) ? a : b;
            if (p > 32767) p = 32767;
            expUMin[ch*16 +: 16]  = 16'(umin);
            expUMax[ch*16 +: 16]  = 16'(umax);
            expSMin[ch*16 +: 16]  = 16'(smin);
            expSMax[ch*16 +: 16]  = 16'(smax);
            expUPeak[ch*16 +: 16] = 16'(umax);
            expSPeak[ch*16 +: 16] = 16'(p);
        end
    endtask

    // One clock cycle: drive at negedge, check ready, advance the model at posedge, check results after it.
    task automatic applyStimulus(input bit rst, input bit v, input logic [15:0] ch0,
                                 input logic [15:0] ch1, input bit rdy);
        bit acc, last;
        @(negedge clk);
        reset  = rst;
        iValid = v;
        iValue = {ch1, ch0};
        oReady = rdy;
        #1;
        expReady = !(cnt == N - 1 && expValid && !rdy);
        if (!rst) begin
            checkOutput("u_i_ready", {31'd0, uReady}, {31'd0, expReady});
            checkOutput("s_i_ready", {31'd0, sReady}, {31'd0, expReady});
        end
        @(posedge clk);
        if (rst) begin
            cnt      = 0;
            expValid = 1'b0;
            expUMin  = 32'hFFFF_FFFF;
            expUMax  = 32'h0000_0000;
            expSMin  = 32'h7FFF_7FFF;
            expSMax  = 32'h8000_8000;
            expUPeak = '0;
            expSPeak = '0;
        end else begin
            acc  = v && expReady;
            last = acc && (cnt == N - 1);
            if (acc) begin
                secBuf[0][cnt] = ch0;
                secBuf[1][cnt] = ch1;
            end
            if (last) begin
                computeSection();
                cnt = 0;
            end else if (acc) begin
                cnt++;
            end
            if (last) expValid = 1'b1;
            else if (rdy) expValid = 1'b0;
        end
        #1;
        checkOutput("u_o_valid", {31'd0, uValid}, {31'd0, expValid});
        checkOutput("s_o_valid", {31'd0, sValid}, {31'd0, expValid});
        checkOutput("u_min", uMin, expUMin);
        checkOutput("u_max", uMax, expUMax);
        checkOutput("s_min", sMin, expSMin);
        checkOutput("s_max", sMax, expSMax);
`ifdef SECTION_MIN_MAX_PEAK_EN
        checkOutput("u_peak", uPeak, expUPeak);
        checkOutput("s_peak", sPeak, expSPeak);
`endif
    endtask

    initial begin
        logic [15:0] dirA [N];
        logic [15:0] dirB [N];
        dirA = '{16'd5, 16'd1, 16'd9, 16'd3};
        dirB = '{16'hFFFD, 16'h0007, 16'h8000, 16'h0002};

        $display("[TB] reset");
        repeat (2) applyStimulus(1, 0, 16'h0, 16'h0, 1);

        $display("[TB] directed sections back to back");
        for (int i = 0; i < N; i++) applyStimulus(0, 1, dirA[i], 16'd0, 1);
        for (int i = 0; i < N; i++) applyStimulus(0, 1, dirB[i], 16'($urandom), 1);
        // Spot checks straight from the worked examples, independent of the model.
        checkOutput("s_ex_ch0_min", {16'd0, sMin[15:0]}, 32'h0000_8000);
        checkOutput("s_ex_ch0_max", {16'd0, sMax[15:0]}, 32'h0000_0007);
`ifdef SECTION_MIN_MAX_PEAK_EN
        checkOutput("s_ex_ch0_peak", {16'd0, sPeak[15:0]}, 32'h0000_7FFF);
`endif
        applyStimulus(0, 0, 16'h0, 16'h0, 1);

        $display("[TB] output overrun stall");
        for (int i = 0; i < N; i++) applyStimulus(0, 1, 16'(100 + i), 16'(200 - i), 1);
        for (int i = 0; i < N + 2; i++)
            applyStimulus(0, 1, 16'(300 + (i < N ? i : N - 1)), 16'(50 + (i < N ? i : N - 1)), 0);
        applyStimulus(0, 1, 16'(300 + N - 1), 16'(50 + N - 1), 1);
        applyStimulus(0, 0, 16'h0, 16'h0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus(0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                          ($urandom_range(0, 9) < 7));
        applyStimulus(0, 0, 16'h0, 16'h0, 1);

        $display("[TB] streaming with i_valid and o_ready held high");
        for (int i = 0; i < 3 * N; i++) applyStimulus(0, 1, 16'($urandom), 16'($urandom), 1);
        applyStimulus(0, 0, 16'h0, 16'h0, 1);

        $display("[TB] reset mid-section");
        applyStimulus(0, 1, 16'h0001, 16'hFFFF, 1);
        applyStimulus(0, 1, 16'h8000, 16'h0000, 1);
        applyStimulus(1, 1, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < N; i++) applyStimulus(0, 1, 16'd2, 16'd2, 1);
        checkOutput("rst_ex_min", uMin, 32'h0002_0002);
        checkOutput("rst_ex_max", uMax, 32'h0002_0002);
        applyStimulus(0, 0, 16'h0, 16'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
